// File: rtl/packet_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// packet_rr_arbiter_if
// Bundles the three-channel FIFO head interface and the merged req/ack output
// link of packet_rr_arbiter.
//   fifo_empty   : per-channel FIFO empty flag (first-word fall-through)
//   fifo_data    : head entry of each FIFO, channel i at [DATA_WIDTH*i +: DATA_WIDTH]
//   fifo_pop     : one-hot pop, consumes the head entry at the clock edge
//   data_out     : merged output byte (registered)
//   data_out_req : data_out valid (registered)
//   data_out_ack : sink accept; transfer when req & ack
//   grant        : one-hot channel owning the link, 0 when idle
//   busy         : packet in progress
// master = arbiter side, slave = FIFO/sink side.
// ---------------------------------------------------------------------------
interface packet_rr_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [2:0]              fifo_empty;
  logic [3*DATA_WIDTH-1:0] fifo_data;
  logic [2:0]              fifo_pop;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    data_out_req;
  logic                    data_out_ack;
  logic [2:0]              grant;
  logic                    busy;

  modport master (
    input  fifo_empty, fifo_data, data_out_ack,
    output fifo_pop, data_out, data_out_req, grant, busy
  );

  modport slave (
    output fifo_empty, fifo_data, data_out_ack,
    input  fifo_pop, data_out, data_out_req, grant, busy
  );
endinterface

// File: rtl/packet_rr_arbiter.sv
// ---------------------------------------------------------------------------
// packet_rr_arbiter
// Merges three per-channel FIFOs onto one req/ack output link. Channels are
// granted round-robin and each packet (header byte carrying the payload length
// LEN in bits [DATA_SIZE+1:2], then LEN payload bytes) is forwarded without
// interleaving.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : packet_rr_arbiter_if.master (FIFO heads/pops, output link,
//           grant, busy)
// ---------------------------------------------------------------------------
module packet_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_SIZE  = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  packet_rr_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_LAST
  } state_t;

  state_t                r_state, w_state_next;
  logic [1:0]            r_rr_ptr, w_rr_ptr_next;
  logic [DATA_SIZE-1:0]  r_remaining, w_remaining_next;
  logic [2:0]            r_grant, w_grant_next;
  logic [DATA_WIDTH-1:0] r_data_out, w_data_out_next;
  logic                  r_req, w_req_next;

  logic [DATA_WIDTH-1:0] w_ch_data [3];
  logic [1:0]            w_cand [3];
  logic                  w_found;
  logic [1:0]            w_win;
  logic [1:0]            w_k;
  logic                  w_out_free;
  logic [DATA_SIZE-1:0]  w_len;
  logic [2:0]            w_pop;

  // Per-channel head byte, and the search order starting at rr_ptr.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      assign w_ch_data[gi] = bus.fifo_data[DATA_WIDTH*gi +: DATA_WIDTH];
      assign w_cand[gi]    = 2'((3'(r_rr_ptr) + 3'(gi)) % 3'd3);
    end
  endgenerate

  // First non-empty candidate wins: scan from the lowest priority upward so
  // the last hit (offset 0 = rr_ptr) overrides.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    for (int off = 2; off >= 0; off--) begin
      if (!bus.fifo_empty[w_cand[off]]) begin
        w_found = 1'b1;
        w_win   = w_cand[off];
      end
    end
  end

  // Index of the channel currently holding the link.
  always_comb begin
    case (r_grant)
      3'b010:  w_k = 2'd1;
      3'b100:  w_k = 2'd2;
      default: w_k = 2'd0;
    endcase
  end

  // The output register can take a new byte when empty or being accepted now.
  assign w_out_free = ~r_req | bus.data_out_ack;
  assign w_len      = w_ch_data[w_win][DATA_SIZE+1:2];

  always_comb begin
    w_state_next     = r_state;
    w_rr_ptr_next    = r_rr_ptr;
    w_remaining_next = r_remaining;
    w_grant_next     = r_grant;
    w_data_out_next  = r_data_out;
    w_req_next       = r_req;
    w_pop            = 3'b000;
    case (r_state)
      S_IDLE: begin
        if (w_found && w_out_free) begin
          w_pop[w_win]     = 1'b1;
          w_data_out_next  = w_ch_data[w_win];
          w_req_next       = 1'b1;
          w_grant_next     = 3'(3'b001 << w_win);
          w_remaining_next = w_len;
          w_state_next     = (w_len != '0) ? S_PAYLOAD : S_LAST;
        end
      end
      S_PAYLOAD: begin
        if (w_out_free) begin
          if (!bus.fifo_empty[w_k]) begin
            w_pop[w_k]      = 1'b1;
            w_data_out_next = w_ch_data[w_k];
            w_req_next      = 1'b1;
            if (r_remaining != '0) begin
              w_remaining_next = r_remaining - 1'b1;
            end
            if (r_remaining <= DATA_SIZE'(1)) begin
              w_state_next = S_LAST;
            end
          end else begin
            // Granted FIFO ran dry mid-packet: stall but keep the grant.
            w_req_next = 1'b0;
          end
        end
      end
      S_LAST: begin
        if (r_req && bus.data_out_ack) begin
          w_req_next    = 1'b0;
          w_grant_next  = 3'b000;
          w_rr_ptr_next = (w_k == 2'd2) ? 2'd0 : w_k + 2'd1;
          w_state_next  = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= 2'd0;
      r_remaining <= '0;
      r_grant     <= 3'b000;
      r_data_out  <= '0;
      r_req       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_remaining <= w_remaining_next;
      r_grant     <= w_grant_next;
      r_data_out  <= w_data_out_next;
      r_req       <= w_req_next;
    end
  end

  // Pop is masked while reset is held so a non-empty FIFO is not drained
  // by the IDLE search during reset.
  assign bus.fifo_pop     = w_pop & {3{rst_n}};
  assign bus.data_out     = r_data_out;
  assign bus.data_out_req = r_req;
  assign bus.grant        = r_grant;
  assign bus.busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_packet_rr_arbiter.sv
module tb_packet_rr_arbiter;
  localparam int DW = 8;
  localparam int DS = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b1;
  always #5 clk = ~clk;

  packet_rr_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  packet_rr_arbiter #(.DATA_WIDTH(DW), .DATA_SIZE(DS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // FIFO model: circular byte buffers with head (popped by DUT) and tail (pushed by tasks)
  logic [7:0] mem  [3][256];
  logic [7:0] head [3];
  logic [7:0] tail [3];
  logic [7:0] mrd  [3];      // reference-model read pointer
  logic [2:0] pop_s;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
      assign bus.fifo_empty[gi]         = (head[gi] == tail[gi]);
      assign bus.fifo_data[DW*gi +: DW] = mem[gi][head[gi]];
      always @(posedge clk) begin
        if (flush) head[gi] <= tail[gi];
        else if (pop_s[gi]) head[gi] <= head[gi] + 8'd1;
      end
    end
  endgenerate

  int n_vec = 0;
  int n_err = 0;

  // Monitor: samples at the falling edge, records accepted bytes
  int         cyc = 0;
  int         pop_viol = 0;
  int         hold_viol = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] got_b [$];
  int         got_ch [$];
  int         got_cy [$];

  function automatic int oh2i(input logic [2:0] g);
    case (g)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 3;
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    pop_s = bus.fifo_pop;
    if (rst_n) begin
      if ($countones(bus.fifo_pop) > 1 || (bus.fifo_pop & bus.fifo_empty) != 3'b000) pop_viol++;
      if (prev_hold && (!bus.data_out_req || bus.data_out != prev_data)) hold_viol++;
      prev_hold = bus.data_out_req && !bus.data_out_ack;
      prev_data = bus.data_out;
      if (bus.data_out_req && bus.data_out_ack) begin
        got_b.push_back(bus.data_out);
        got_ch.push_back(oh2i(bus.grant));
        got_cy.push_back(cyc);
        $display("xfer cyc=%0d ch=%0d data=%02h", cyc, oh2i(bus.grant), bus.data_out);
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Reference model: packet-level round robin over fully queued packets
  logic [7:0] exp_b [$];
  int         exp_ch [$];
  bit         exp_first [$];
  int         exp_ptr = 0;

  task automatic model_run();
    exp_b.delete(); exp_ch.delete(); exp_first.delete();
    while (mrd[0] != tail[0] || mrd[1] != tail[1] || mrd[2] != tail[2]) begin
      int k;
      int len;
      logic [7:0] h;
      k = -1;
      for (int off = 0; off < 3; off++) begin
        int c;
        c = (exp_ptr + off) % 3;
        if (k < 0 && mrd[c] != tail[c]) k = c;
      end
      h = mem[k][mrd[k]];
      len = int'(h[7:2]);
      for (int j = 0; j <= len; j++) begin
        exp_b.push_back(mem[k][mrd[k]]);
        exp_ch.push_back(k);
        exp_first.push_back(j == 0);
        mrd[k] = mrd[k] + 8'd1;
      end
      exp_ptr = (k + 1) % 3;
    end
  endtask

  task automatic push(input int ch, input logic [7:0] b);
    mem[ch][tail[ch]] = b;
    tail[ch] = tail[ch] + 8'd1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_n(input int n, input int budget, output bit ok);
    int t;
    t = 0;
    while (got_b.size() < n && t < budget) begin
      step(1);
      t++;
    end
    ok = (got_b.size() >= n);
  endtask

  task automatic clear_got();
    got_b.delete(); got_ch.delete(); got_cy.delete();
  endtask

  task automatic flush_all();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) mrd[i] = tail[i];
    exp_ptr = 0;
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0;
    bus.data_out_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin tail[i] = 8'd0; mrd[i] = 8'd0; end
    step(2);
    flush = 1'b0;
    push(0, 8'h00);
    #1;
    n_vec++; if (bus.fifo_pop !== 3'b000) begin n_err++; $display("FAIL reset_pop got=%b exp=000", bus.fifo_pop); end
    n_vec++; if (bus.data_out !== 8'h00) begin n_err++; $display("FAIL reset_data got=%02h exp=00", bus.data_out); end
    n_vec++; if (bus.data_out_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", bus.data_out_req); end
    n_vec++; if (bus.grant !== 3'b000) begin n_err++; $display("FAIL reset_grant got=%b exp=000", bus.grant); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    flush_all();
    rst_n = 1'b1;
    step(2);
    ok = 1'b1;
    n_vec++; if (bus.busy !== 1'b0 || !ok) begin n_err++; $display("FAIL reset_idle busy=%b exp=0", bus.busy); end
  endtask

  task automatic test_single_packet();
    bit ok;
    clear_got();
    bus.data_out_ack = 1'b1;
    push(1, 8'h0D); push(1, 8'hA1); push(1, 8'hA2); push(1, 8'hA3);
    model_run();
    #1;
    n_vec++; if (bus.fifo_pop !== 3'b010) begin n_err++; $display("FAIL single_pop got=%b exp=010", bus.fifo_pop); end
    n_vec++; if (bus.grant !== 3'b000) begin n_err++; $display("FAIL single_grant0 got=%b exp=000", bus.grant); end
    step(1);
    n_vec++; if (bus.grant !== 3'b010) begin n_err++; $display("FAIL single_grant got=%b exp=010", bus.grant); end
    n_vec++; if (bus.data_out_req !== 1'b1 || bus.data_out !== 8'h0D) begin n_err++; $display("FAIL single_hdr req=%b data=%02h exp req=1 data=0d", bus.data_out_req, bus.data_out); end
    wait_n(exp_b.size(), 50, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL single_timeout got=%0d bytes exp=%0d", got_b.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      n_vec++;
      if (got_b[i] !== exp_b[i] || got_ch[i] !== exp_ch[i] || (i > 0 && got_cy[i] - got_cy[i-1] != 1)) begin
        n_err++; $display("FAIL single_byte%0d got=%02h/ch%0d exp=%02h/ch%0d", i, got_b[i], got_ch[i], exp_b[i], exp_ch[i]);
      end
    end
    n_vec++; if (bus.grant !== 3'b000 || bus.busy !== 1'b0) begin n_err++; $display("FAIL single_done grant=%b busy=%b exp=000/0", bus.grant, bus.busy); end
    // rr_ptr should now point at ch2: ch2 beats ch0
    clear_got();
    push(0, 8'h00); push(2, 8'h02);
    model_run();
    wait_n(2, 50, ok);
    n_vec++; if (!ok || got_ch[0] !== 2 || got_ch[1] !== 0) begin n_err++; $display("FAIL single_ptr got=ch%0d,ch%0d exp=ch2,ch0", got_ch[0], got_ch[1]); end
  endtask

  task automatic test_round_robin();
    bit ok;
    clear_got();
    bus.data_out_ack = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int ch = 0; ch < 3; ch++) begin
        push(ch, 8'((1 << 2) | ch));
        push(ch, 8'($urandom));
      end
    model_run();
    wait_n(exp_b.size(), 100, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rr_timeout got=%0d exp=%0d", got_b.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      n_vec++;
      if (got_b[i] !== exp_b[i] || got_ch[i] !== exp_ch[i] ||
          (i > 0 && got_cy[i] - got_cy[i-1] != (exp_first[i] ? 2 : 1))) begin
        n_err++; $display("FAIL rr_byte%0d got=%02h/ch%0d exp=%02h/ch%0d", i, got_b[i], got_ch[i], exp_b[i], exp_ch[i]);
      end
    end
  endtask

  task automatic test_zero_length();
    bit ok;
    clear_got();
    bus.data_out_ack = 1'b1;
    push(0, 8'h00);
    push(1, 8'h05); push(1, 8'h55);
    model_run();
    wait_n(exp_b.size(), 50, ok);
    n_vec++; if (!ok || got_b.size() != 3) begin n_err++; $display("FAIL zero_count got=%0d exp=3", got_b.size()); end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      n_vec++;
      if (got_b[i] !== exp_b[i] || got_ch[i] !== exp_ch[i] ||
          (i > 0 && got_cy[i] - got_cy[i-1] != (exp_first[i] ? 2 : 1))) begin
        n_err++; $display("FAIL zero_byte%0d got=%02h/ch%0d exp=%02h/ch%0d", i, got_b[i], got_ch[i], exp_b[i], exp_ch[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0] b1;
    b1 = 8'($urandom);
    clear_got();
    bus.data_out_ack = 1'b0;
    push(0, 8'h08); push(0, b1); push(0, 8'($urandom));
    model_run();
    step(1);
    bus.data_out_ack = 1'b1;
    step(1);
    bus.data_out_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (bus.data_out !== b1 || bus.data_out_req !== 1'b1 || bus.fifo_pop !== 3'b000) begin
        n_err++; $display("FAIL bp_stall%0d data=%02h req=%b pop=%b exp=%02h/1/000", i, bus.data_out, bus.data_out_req, bus.fifo_pop, b1);
      end
      step(1);
    end
    bus.data_out_ack = 1'b1;
    wait_n(exp_b.size(), 50, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL bp_timeout got=%0d exp=%0d", got_b.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      n_vec++;
      if (got_b[i] !== exp_b[i] || got_ch[i] !== exp_ch[i]) begin
        n_err++; $display("FAIL bp_byte%0d got=%02h/ch%0d exp=%02h/ch%0d", i, got_b[i], got_ch[i], exp_b[i], exp_ch[i]);
      end
    end
    n_vec++; if (hold_viol !== 0 || pop_viol !== 0) begin n_err++; $display("FAIL bp_protocol hold=%0d pop=%0d exp=0/0", hold_viol, pop_viol); end
  endtask

  task automatic test_underflow();
    bit ok;
    clear_got();
    bus.data_out_ack = 1'b1;
    push(2, 8'h12); push(2, 8'hC1); push(2, 8'hC2);
    push(0, 8'h00);
    wait_n(3, 50, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL uf_timeout got=%0d exp=3", got_b.size()); end
    for (int i = 0; i < 3; i++) begin
      step(1);
      #1;
      n_vec++;
      if (bus.data_out_req !== 1'b0 || bus.grant !== 3'b100 || bus.busy !== 1'b1 || bus.fifo_pop !== 3'b000) begin
        n_err++; $display("FAIL uf_stall%0d req=%b grant=%b busy=%b pop=%b exp=0/100/1/000", i, bus.data_out_req, bus.grant, bus.busy, bus.fifo_pop);
      end
    end
    push(2, 8'hC3); push(2, 8'hC4);
    model_run();
    wait_n(exp_b.size(), 50, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL uf_timeout2 got=%0d exp=%0d", got_b.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      n_vec++;
      if (got_b[i] !== exp_b[i] || got_ch[i] !== exp_ch[i]) begin
        n_err++; $display("FAIL uf_byte%0d got=%02h/ch%0d exp=%02h/ch%0d", i, got_b[i], got_ch[i], exp_b[i], exp_ch[i]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    clear_got();
    bus.data_out_ack = 1'b1;
    push(0, 8'h14);
    for (int i = 0; i < 5; i++) push(0, 8'($urandom));
    wait_n(2, 50, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rstmid_timeout got=%0d exp=2", got_b.size()); end
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.data_out !== 8'h00 || bus.data_out_req !== 1'b0 || bus.grant !== 3'b000 ||
        bus.busy !== 1'b0 || bus.fifo_pop !== 3'b000) begin
      n_err++; $display("FAIL rstmid_async data=%02h req=%b grant=%b busy=%b pop=%b exp=all 0", bus.data_out, bus.data_out_req, bus.grant, bus.busy, bus.fifo_pop);
    end
    flush_all();
    rst_n = 1'b1;
    clear_got();
    push(1, 8'h05); push(1, 8'h77);
    push(0, 8'h00);
    model_run();
    wait_n(exp_b.size(), 50, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rstmid_timeout2 got=%0d exp=%0d", got_b.size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      n_vec++;
      if (got_b[i] !== exp_b[i] || got_ch[i] !== exp_ch[i]) begin
        n_err++; $display("FAIL rstmid_byte%0d got=%02h/ch%0d exp=%02h/ch%0d", i, got_b[i], got_ch[i], exp_b[i], exp_ch[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int t;
    for (int r = 0; r < 6; r++) begin
      clear_got();
      for (int ch = 0; ch < 3; ch++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          int len;
          len = $urandom_range(0, 6);
          push(ch, 8'((len << 2) | ch));
          for (int j = 0; j < len; j++) push(ch, 8'($urandom));
        end
      end
      model_run();
      t = 0;
      while (got_b.size() < exp_b.size() && t < 600) begin
        bus.data_out_ack = ($urandom_range(0, 3) != 0);
        step(1);
        t++;
      end
      bus.data_out_ack = 1'b1;
      step(2);
      n_vec++; if (got_b.size() != exp_b.size()) begin n_err++; $display("FAIL rand%0d_count got=%0d exp=%0d", r, got_b.size(), exp_b.size()); end
      for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
        n_vec++;
        if (got_b[i] !== exp_b[i] || got_ch[i] !== exp_ch[i]) begin
          n_err++; $display("FAIL rand%0d_byte%0d got=%02h/ch%0d exp=%02h/ch%0d", r, i, got_b[i], got_ch[i], exp_b[i], exp_ch[i]);
        end
      end
    end
    n_vec++; if (hold_viol !== 0 || pop_viol !== 0) begin n_err++; $display("FAIL rand_protocol hold=%0d pop=%0d exp=0/0", hold_viol, pop_viol); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data_out_ack = 1'b0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_zero_length();
    test_backpressure();
    test_underflow();
    test_reset_mid_packet();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/packet_rr_arbiter.md
Name: packet_rr_arbiter

Overview:
- Merges the three per-channel FIFOs of the router onto one shared output link.
- Grants channels round-robin and forwards each packet atomically: one header byte, then its payload. Packets are never interleaved.
- Sits between the fifo_synch instances and a single req/ack output port. It replaces per-channel output_logic where the router drives a merged link.

Parameters:
- DATA_WIDTH, 8, byte width of FIFO entries and output link.
- DATA_SIZE, 6, width of the header length field; max payload 2**DATA_SIZE-1 bytes.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  3  per-channel FIFO empty flag.
- fifo_data  input  3*DATA_WIDTH  head entry of each FIFO; channel i at [DATA_WIDTH*i +: DATA_WIDTH]. First-word fall-through: valid whenever fifo_empty[i]=0.
- fifo_pop  output  3  one-hot pop; removes the head entry at the clock edge.
- data_out  output  DATA_WIDTH  merged output byte, registered.
- data_out_req  output  1  data_out valid, registered.
- data_out_ack  input  1  sink accept; a transfer occurs in any cycle with req=1 and ack=1.
- grant  output  3  one-hot channel currently owning the link; 0 when idle.
- busy  output  1  packet in progress (state != IDLE).

Behaviour:
- Reset (async, rst_n=0):
  - data_out=0, data_out_req=0, fifo_pop=0, grant=0, busy=0.
  - state=IDLE, rr_ptr=0, remaining=0.
  - A reset mid-packet drops the remainder. The FIFO contents are untouched.
- Header format: bits [DATA_SIZE+1:2] = payload length LEN (0 is legal); bits [1:0] = address (ignored here).
- Output register is "free" when data_out_req=0, or when data_out_req=1 and data_out_ack=1 (being accepted this cycle).
- Once data_out_req=1, data_out is held stable until the ack cycle.
- States:
  - IDLE:
    - Candidate search order is rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). The first channel with fifo_empty=0 wins.
    - If a winner k exists and the output register is free: fifo_pop[k]=1 (combinational, this cycle); data_out<=fifo_data[k]; data_out_req<=1; grant<=one-hot k; remaining<=LEN.
    - Next state is PAYLOAD if LEN>0, else LAST.
    - Latency from fifo_empty falling to data_out_req rising is 1 cycle.
  - PAYLOAD:
    - If output free and fifo_empty[k]=0: pop, load byte, req<=1, remaining<=remaining-1. When remaining==1, go to LAST.
    - If output free and fifo_empty[k]=1: req<=0 (stall). Stay in PAYLOAD; the grant is held.
    - If output not free: hold everything, no pop.
  - LAST (final byte loaded, waiting acceptance):
    - On req&ack: req<=0, grant<=0, rr_ptr<=(k+1) mod 3, state<=IDLE.
    - No pop in LAST. A new header is popped in IDLE no earlier than the cycle after the last ack, giving a 1-cycle bubble between packets.
- At most one fifo_pop bit is high at any time, and never to an empty FIFO.
- fifo_pop is combinational from state, registered grant, fifo_empty and data_out_ack. It has no combinational path from fifo_data.
- Back-to-back throughput within a packet is 1 byte/cycle while ack is held high.
- Other channels becoming non-empty mid-packet have no effect until IDLE.
- remaining is DATA_SIZE bits wide and never decrements below 0.
- busy = (state != IDLE).

Test Plan:
1. Reset then single packet: ch1 FIFO holds header 0x0D (LEN=3, addr 1) plus 0xA1,0xA2,0xA3; ack tied 1 -> grant=3'b010 one cycle after fifo_empty[1] falls. data_out sequence is 0x0D,0xA1,0xA2,0xA3 on 4 consecutive req&ack cycles. Then grant=0, busy=0, rr_ptr=2.
2. Round-robin fairness: all three FIFOs hold two packets each with LEN=1; ack=1 -> channel service order is 0,1,2,0,1,2. There is exactly one req=0 bubble between packets and no interleaving of bytes.
3. Backpressure: ch0 packet LEN=2; ack low for 5 cycles on the second byte -> data_out is stable at byte 2 with req=1 throughout. No fifo_pop asserts during the stall. Completion follows on the ack.
4. Mid-packet underflow: ch2 header LEN=4, only 2 payload bytes present, ch0 non-empty -> req drops after byte 2 and grant stays 3'b100. ch0 is not served. Pushing the remaining 2 bytes resumes ch2 and it completes.
5. Zero-length packet: ch0 header 0x00, ch1 header 0x05 (LEN=1) + 0x55 -> ch0 emits one byte, goes straight to LAST then IDLE. ch1 follows with 0x05,0x55.
6. Reset mid-packet: assert rst_n=0 during byte 2 of a LEN=5 packet -> all outputs are 0 immediately (async) and rr_ptr=0. After release, arbitration restarts from ch0 priority.
